centroid_tracker: RTL

//  Downstream consumer of the filtered pixel stream (RGB565 + hcount/vcount).
//  - Thresholds each pixel into a 1-bit mask and forwards that mask, with 1-cycle latency, to the display overlay.
//  - Accumulates x/y sums and a pixel count of masked pixels over each frame.
//  - At frame end, computes the centroid of the masked object with an iterative divider.

---
 rtl/juggler_pkg.sv | 30 +++
 rtl/divider_iter.sv | 75 +++++++
 rtl/centroid_tracker.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/juggler_pkg.sv
// Shared types and defaults for the juggler video pipeline: frame geometry,
// centroid-tracker FSM states and the RGB565 pixel layout.
package juggler_pkg;

  localparam int HRES_DEF = 1280;
  localparam int VRES_DEF = 720;
  localparam int SUM_W    = 32;
  localparam int CNT_W    = 20;

  typedef enum logic [1:0] {
    ACCUM,
    DIV_X,
    DIV_Y,
    PUBLISH
  } tracker_state_t;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  // Inclusive range test; an inverted range (lo > hi) never matches.
  function automatic logic in_range(input logic [5:0] v,
                                    input logic [5:0] lo,
                                    input logic [5:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/divider_iter.sv
// Restoring divider, 32-bit dividend by 20-bit divisor, one quotient bit per cycle.
// The first bit is resolved on the start edge, so done_out rises 32 cycles after start_in.
module divider_iter
  import juggler_pkg::*;
(
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             start_in,
  input  logic [SUM_W-1:0] dividend_in,
  input  logic [CNT_W-1:0] divisor_in,
  output logic             busy_out,
  output logic             done_out,
  output logic [SUM_W-1:0] quotient_out
);

  logic [CNT_W-1:0] rem_q, rem_d, div_q, src_rem, src_div;
  logic [SUM_W-1:0] quo_q, quo_d, src_quo;
  logic [4:0]       iter_q;
  logic             busy_q, done_q;

  function automatic logic [CNT_W+SUM_W-1:0] div_step(input logic [CNT_W-1:0] rem,
                                                      input logic [SUM_W-1:0] quo,
                                                      input logic [CNT_W-1:0] dvs);
    logic [CNT_W:0] trial;
    trial = {rem, quo[SUM_W-1]};
    if (trial >= {1'b0, dvs}) begin
      trial = trial - {1'b0, dvs};
      return {trial[CNT_W-1:0], quo[SUM_W-2:0], 1'b1};
    end
    return {trial[CNT_W-1:0], quo[SUM_W-2:0], 1'b0};
  endfunction

  always_comb begin
    src_rem = rem_q;
    src_quo = quo_q;
    src_div = div_q;
    if (start_in) begin
      src_rem = '0;
      src_quo = dividend_in;
      src_div = divisor_in;
    end
    {rem_d, quo_d} = div_step(src_rem, src_quo, src_div);
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      rem_q  <= '0;
      quo_q  <= '0;
      div_q  <= '0;
      iter_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else if (start_in) begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      div_q  <= divisor_in;
      iter_q <= 5'd1;
      busy_q <= 1'b1;
      done_q <= 1'b0;
    end else if (busy_q) begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      iter_q <= iter_q + 5'd1;
      busy_q <= (iter_q != 5'd31);
      done_q <= (iter_q == 5'd31);
    end else begin
      done_q <= 1'b0;
    end
  end

  assign busy_out     = busy_q;
  assign done_out     = done_q;
  assign quotient_out = quo_q;

endmodule

// File: rtl/centroid_tracker.sv
// Thresholds the filtered pixel stream into a mask for the overlay and reports the
// per-frame centroid of masked pixels, computed by a shared iterative divider.
module centroid_tracker
  import juggler_pkg::*;
#(
  parameter int HRES      = HRES_DEF,
  parameter int VRES      = VRES_DEF,
  parameter int MIN_COUNT = 64
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        data_valid_in,
  input  logic [15:0] pixel_data_in,
  input  logic [10:0] hcount_in,
  input  logic [9:0]  vcount_in,
  input  logic [4:0]  r_min_in,
  input  logic [4:0]  r_max_in,
  input  logic [5:0]  g_min_in,
  input  logic [5:0]  g_max_in,
  input  logic [4:0]  b_min_in,
  input  logic [4:0]  b_max_in,
  output logic        mask_valid_out,
  output logic        mask_out,
  output logic [10:0] hcount_out,
  output logic [9:0]  vcount_out,
  output logic [10:0] x_out,
  output logic [9:0]  y_out,
  output logic        found_out,
  output logic        valid_out,
  output logic        overrun_out
);

  localparam logic [10:0]      H_LAST  = 11'(HRES - 1);
  localparam logic [9:0]       V_LAST  = 10'(VRES - 1);
  localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_COUNT);

  generate
    if (MIN_COUNT < 1) begin : g_min_count_check
      $error("centroid_tracker: MIN_COUNT must be at least 1");
    end
  endgenerate

  rgb565_t px;
  logic    mask_c, take_c, frame_end_c;

  assign px     = rgb565_t'(pixel_data_in);
  assign mask_c = in_range({1'b0, px.r}, {1'b0, r_min_in}, {1'b0, r_max_in}) &&
                  in_range(px.g, g_min_in, g_max_in) &&
                  in_range({1'b0, px.b}, {1'b0, b_min_in}, {1'b0, b_max_in});
  assign take_c      = data_valid_in && mask_c;
  assign frame_end_c = data_valid_in && (hcount_in == H_LAST) && (vcount_in == V_LAST);

  logic        mask_valid_q, mask_q;
  logic [10:0] hcount_q;
  logic [9:0]  vcount_q;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      mask_valid_q <= 1'b0;
      mask_q       <= 1'b0;
      hcount_q     <= '0;
      vcount_q     <= '0;
    end else begin
      mask_valid_q <= data_valid_in;
      mask_q       <= mask_c;
      hcount_q     <= hcount_in;
      vcount_q     <= vcount_in;
    end
  end

  // Snapshot includes the current pixel; frame end restarts the sums with no gap.
  logic [SUM_W-1:0] sum_x_q, sum_y_q, sum_x_d, sum_y_d, snap_x, snap_y;
  logic [CNT_W-1:0] cnt_q, cnt_d, snap_cnt;

  always_comb begin
    snap_x   = sum_x_q + (take_c ? SUM_W'(hcount_in) : '0);
    snap_y   = sum_y_q + (take_c ? SUM_W'(vcount_in) : '0);
    snap_cnt = cnt_q + CNT_W'(take_c);
    sum_x_d  = frame_end_c ? '0 : snap_x;
    sum_y_d  = frame_end_c ? '0 : snap_y;
    cnt_d    = frame_end_c ? '0 : snap_cnt;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      sum_x_q <= '0;
      sum_y_q <= '0;
      cnt_q   <= '0;
    end else begin
      sum_x_q <= sum_x_d;
      sum_y_q <= sum_y_d;
      cnt_q   <= cnt_d;
    end
  end

  tracker_state_t   state_q;
  logic [SUM_W-1:0] snap_y_q, div_dividend, div_quo;
  logic [CNT_W-1:0] snap_cnt_q, div_divisor;
  logic [10:0]      qx_q, x_q;
  logic [9:0]       y_q;
  logic             found_frame_q, found_q, valid_q, overrun_q;
  logic             start_x, start_y, div_start, div_busy, div_done;

  assign start_x      = (state_q == ACCUM) && frame_end_c && (snap_cnt >= MIN_CNT);
  assign start_y      = (state_q == DIV_X) && div_done;
  assign div_start    = start_x || start_y;
  assign div_dividend = start_x ? snap_x : snap_y_q;
  assign div_divisor  = start_x ? snap_cnt : snap_cnt_q;

  divider_iter u_div (
    .clk_in       (clk_in),
    .rst_n_in     (rst_n_in),
    .start_in     (div_start),
    .dividend_in  (div_dividend),
    .divisor_in   (div_divisor),
    .busy_out     (div_busy),
    .done_out     (div_done),
    .quotient_out (div_quo)
  );

  logic unused_div;
  assign unused_div = div_busy ^ (^div_quo[SUM_W-1:11]);

  // Found results land as DIV_Y completes; an unfound frame publishes from PUBLISH itself.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q       <= ACCUM;
      snap_y_q      <= '0;
      snap_cnt_q    <= '0;
      qx_q          <= '0;
      x_q           <= '0;
      y_q           <= '0;
      found_frame_q <= 1'b0;
      found_q       <= 1'b0;
      valid_q       <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      valid_q   <= 1'b0;
      overrun_q <= frame_end_c && (state_q != ACCUM);
      case (state_q)
        ACCUM: begin
          if (frame_end_c) begin
            found_frame_q <= start_x;
            snap_y_q      <= snap_y;
            snap_cnt_q    <= snap_cnt;
            state_q       <= start_x ? DIV_X : PUBLISH;
          end
        end
        DIV_X: begin
          if (div_done) begin
            qx_q    <= div_quo[10:0];
            state_q <= DIV_Y;
          end
        end
        DIV_Y: begin
          if (div_done) begin
            x_q     <= qx_q;
            y_q     <= div_quo[9:0];
            found_q <= 1'b1;
            valid_q <= 1'b1;
            state_q <= PUBLISH;
          end
        end
        PUBLISH: begin
          if (!found_frame_q) begin
            found_q <= 1'b0;
            valid_q <= 1'b1;
          end
          state_q <= ACCUM;
        end
        default: state_q <= ACCUM;
      endcase
    end
  end

  assign mask_valid_out = mask_valid_q;
  assign mask_out       = mask_q;
  assign hcount_out     = hcount_q;
  assign vcount_out     = vcount_q;
  assign x_out          = x_q;
  assign y_out          = y_q;
  assign found_out      = found_q;
  assign valid_out      = valid_q;
  assign overrun_out    = overrun_q;

endmodule
